pc_fetch_unit: RTL

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

---
 rtl/fetch_pkg.sv | 25 ++
 rtl/fetch_out_reg.sv | 57 +++++
 rtl/pc_fetch_unit.sv | 108 ++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch unit: FSM state encoding,
// the NOP word loaded into the instruction register at reset, the default
// reset PC and a helper that forces an address onto a word boundary.
// -----------------------------------------------------------------------------
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_e;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Redirect targets come straight from the ALU; drop the byte offset.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_out_reg.sv
// -----------------------------------------------------------------------------
// fetch_out_reg
// Holding register between fetch and decode. Keeps one instruction and its
// PC until decode consumes it.
//   clk, rst_n   clock / asynchronous active-low reset
//   capture_i    load pc_i/instr_i and mark valid
//   flush_i      discard the held instruction (redirect); wins over capture
//   consume_i    decode ready; clears valid when nothing new is captured
//   pc_i         PC of the instruction being captured
//   instr_i      instruction word being captured
//   if_valid_o   register holds an instruction
//   if_pc_o      PC of the held instruction
//   if_instr_o   held instruction word
// -----------------------------------------------------------------------------
module fetch_out_reg
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        capture_i,
  input  logic        flush_i,
  input  logic        consume_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_i,
  output logic        if_valid_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_instr_o
);

  logic        valid_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;

  // pc/instr only change on capture, so they stay stable while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= 32'h0000_0000;
      instr_q <= NOP_INSTR;
    end else begin
      if (flush_i) begin
        valid_q <= 1'b0;
      end else if (capture_i) begin
        valid_q <= 1'b1;
        pc_q    <= pc_i;
        instr_q <= instr_i;
      end else if (consume_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign if_valid_o = valid_q;
  assign if_pc_o    = pc_q;
  assign if_instr_o = instr_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
// Sequential instruction fetch with branch redirect. One imem request is
// outstanding at a time; a redirect that races an accepted request parks the
// FSM in DRAIN until the stale response has been absorbed.
//   clk, rst_n       clock / asynchronous active-low reset
//   br_valid         a resolved control-transfer instruction this cycle
//   NextPCSrc        1 = redirect to br_target (qualified by br_valid)
//   br_target        redirect address
//   imem_req_*       request channel (valid/ready/addr)
//   imem_rsp_*       response channel (valid/ready/data)
//   if_valid/if_pc/if_instr/if_ready   decode-side holding register handshake
// -----------------------------------------------------------------------------
module pc_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        br_valid,
  input  logic        NextPCSrc,
  input  logic [31:0] br_target,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        imem_rsp_ready,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        if_ready
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;

  logic redirect;
  logic req_hs;
  logic rsp_hs;
  logic capture;

  assign redirect = br_valid & NextPCSrc;

  // Request side is decoded purely from registered state.
  assign imem_req_valid = (state_q == ST_FETCH);
  assign imem_req_addr  = pc_q;

  // In WAIT only accept a response if the holding register can take it.
  assign imem_rsp_ready = (state_q == ST_DRAIN) |
                          ((state_q == ST_WAIT) & (~if_valid | if_ready));

  assign req_hs  = imem_req_valid & imem_req_ready;
  assign rsp_hs  = imem_rsp_valid & imem_rsp_ready;
  assign capture = (state_q == ST_WAIT) & rsp_hs & ~redirect;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
    end else begin
      if (redirect) begin
        pc_q <= align_word(br_target);
      end else if (capture) begin
        pc_q <= pc_q + 32'd4;
      end

      case (state_q)
        ST_IDLE: state_q <= ST_FETCH;
        ST_FETCH: begin
          // Unaccepted request under redirect is simply withdrawn; the new
          // pc is presented next cycle. An accepted one must be drained.
          if (req_hs) begin
            state_q <= redirect ? ST_DRAIN : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (redirect) begin
            state_q <= rsp_hs ? ST_FETCH : ST_DRAIN;
          end else if (rsp_hs) begin
            state_q <= ST_FETCH;
          end
        end
        ST_DRAIN: begin
          if (rsp_hs) begin
            state_q <= ST_FETCH;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  fetch_out_reg u_out_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .capture_i  (capture),
    .flush_i    (redirect),
    .consume_i  (if_ready),
    .pc_i       (pc_q),
    .instr_i    (imem_rsp_data),
    .if_valid_o (if_valid),
    .if_pc_o    (if_pc),
    .if_instr_o (if_instr)
  );

endmodule
